// File: rtl/tqvp_bus_pkg.sv
// Shared types and constants for the TinyQV peripheral-port arbiter and its helpers.
package tqvp_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Transaction widths double as the active-low strobe encoding on the peripheral port.
    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_WORD = 2'b10;
    localparam logic [1:0] TXN_NONE = 2'b11;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/tqvp_bus_arbiter_if.sv
// Requester-side and peripheral-side signals of the two-requester TinyQV port arbiter.
interface tqvp_bus_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_write;
    logic [1:0][1:0]         req_txn;
    logic [1:0][ADDR_W-1:0]  req_addr;
    logic [1:0][DATA_W-1:0]  req_wdata;
    logic [1:0]              req_ack;
    logic [1:0]              req_done;
    logic [DATA_W-1:0]       req_rdata;
    logic                    req_err;

    logic [ADDR_W-1:0]       per_address;
    logic [DATA_W-1:0]       per_data_in;
    logic [1:0]              per_data_write_n;
    logic [1:0]              per_data_read_n;
    logic [DATA_W-1:0]       per_data_out;
    logic                    per_data_ready;

    // Arbiter view.
    modport slave (
        input  req_valid, req_write, req_txn, req_addr, req_wdata,
        input  per_data_out, per_data_ready,
        output req_ack, req_done, req_rdata, req_err,
        output per_address, per_data_in, per_data_write_n, per_data_read_n
    );

    // Environment view: requesters plus peripheral.
    modport master (
        output req_valid, req_write, req_txn, req_addr, req_wdata,
        output per_data_out, per_data_ready,
        input  req_ack, req_done, req_rdata, req_err,
        input  per_address, per_data_in, per_data_write_n, per_data_read_n
    );

endinterface

// File: rtl/tqvp_rdata_mask.sv
// Combinational read-data masker: keeps only the bytes covered by the transaction width.
module tqvp_rdata_mask
    import tqvp_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        txn_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (txn_i == TXN_BYTE) begin
            data_o[DATA_W-1:8] = '0;
        end else if (txn_i == TXN_HALF) begin
            data_o[DATA_W-1:16] = '0;
        end
    end

endmodule

// File: rtl/tqvp_bus_arbiter.sv
// Round-robin arbiter sharing one TinyQV peripheral register port between two requesters.
// Optional read timeout enabled by defining ARB_TIMEOUT_EN.
module tqvp_bus_arbiter
    import tqvp_bus_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    tqvp_bus_arbiter_if.slave  bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("tqvp_bus_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e         state_q, state_d;
    logic               last_q, last_d;
    logic               win_q, win_d;
    logic [1:0]         txn_q, txn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [1:0]         ack_q, ack_d;

    logic               grant;
    logic [1:0]         wr_n, rd_n, done;
    logic [DATA_W-1:0]  rd_masked;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Contention goes to whoever did not win last; otherwise the lone requester.
    assign grant = (&bus.req_valid) ? ~last_q : bus.req_valid[1];

    tqvp_rdata_mask #(.DATA_W(DATA_W)) u_mask (
        .txn_i  (txn_q),
        .data_i (bus.per_data_out),
        .data_o (rd_masked)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        txn_d   = txn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack_d   = '0;
        wr_n    = TXN_NONE;
        rd_n    = TXN_NONE;
        done    = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    last_d       = grant;
                    win_d        = grant;
                    txn_d        = bus.req_txn[grant];
                    addr_d       = bus.req_addr[grant];
                    wdata_d      = bus.req_wdata[grant];
                    ack_d[grant] = 1'b1;
                    err_d        = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    if (bus.req_txn[grant] == TXN_NONE) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (bus.req_write[grant]) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                wr_n    = txn_q;
                rdata_d = '0;
                state_d = DONE;
            end
            READ: begin
                rd_n = txn_q;
                if (bus.per_data_ready) begin
                    rdata_d = rd_masked;
                    state_d = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = DATA_W'(TIMEOUT_DATA);
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                done[win_q] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            txn_q   <= TXN_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            txn_q   <= txn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign bus.req_ack          = ack_q;
    assign bus.req_done         = done;
    assign bus.req_rdata        = rdata_q;
    assign bus.req_err          = (state_q == DONE) && err_q;
    assign bus.per_address      = addr_q;
    assign bus.per_data_in      = wdata_q;
    assign bus.per_data_write_n = wr_n;
    assign bus.per_data_read_n  = rd_n;

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Self-checking bench for tqvp_bus_arbiter: directed vector table, hand sequences, randomized traffic.
module tb_tqvp_bus_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct {
        bit          wr;
        logic [1:0]  txn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } item_t;

    typedef struct {
        int          who;
        logic [DW-1:0] rdata;
        bit          err;
        int          cyc;
        int          ns;
        logic [1:0]  sv;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit          stable;
    } done_t;

    typedef struct {
        int who;
        int cyc;
    } ack_t;

    typedef struct {
        int          r;
        bit          wr;
        logic [1:0]  txn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] pdata;
        int          dly;
        logic [DW-1:0] xrd;
        bit          xerr;
        int          xlat;
        int          xns;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    item_t q0[$];
    item_t q1[$];
    done_t dq[$];
    ack_t  aq[$];

    bit            use_hash = 1'b0;
    bit            rand_rdy = 1'b0;
    bit            spur     = 1'b0;
    int            rd_delay = 0;
    logic [DW-1:0] per_word = '0;
    int            model_last = 1;

    int            rc;
    int            ns;
    logic [1:0]    sv;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit            stab;
    done_t         drec;
    ack_t          arec;

    tqvp_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    tqvp_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pdata_of(input logic [AW-1:0] a);
        return {4{a, 2'b01}} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [DW-1:0] width_mask(input logic [1:0] txn, input logic [DW-1:0] d);
        if (txn == 2'b00) return d % 32'h100;
        if (txn == 2'b01) return d % 32'h1_0000;
        return d;
    endfunction

    assign bus.per_data_out = use_hash ? pdata_of(bus.per_address) : per_word;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, got, exp);
        end
    endtask

    // Requesters: present the head of each queue, pop on ack.
    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_txn   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.req_ack[0] && q0.size() > 0) void'(q0.pop_front());
            if (bus.req_ack[1] && q1.size() > 0) void'(q1.pop_front());
            bus.req_valid = {q1.size() > 0, q0.size() > 0};
            if (q0.size() > 0) begin
                bus.req_write[0] = q0[0].wr;  bus.req_txn[0]   = q0[0].txn;
                bus.req_addr[0]  = q0[0].addr; bus.req_wdata[0] = q0[0].wd;
            end
            if (q1.size() > 0) begin
                bus.req_write[1] = q1[0].wr;  bus.req_txn[1]   = q1[0].txn;
                bus.req_addr[1]  = q1[0].addr; bus.req_wdata[1] = q1[0].wd;
            end
        end
    end

    // Peripheral: ready after rd_delay strobe cycles, or random; optional spurious ready.
    initial begin
        rc = 0;
        bus.per_data_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.per_data_read_n != 2'b11) begin
                rc++;
                bus.per_data_ready = rand_rdy ? 1'($urandom_range(0, 1)) : (rc > rd_delay);
            end else begin
                rc = 0;
                bus.per_data_ready = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: collects ack/done events and checks per-cycle invariants.
    initial begin
        ns = 0; sv = 2'b11; stab = 1'b1; a0 = '0; d0 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ns = 0; sv = 2'b11; stab = 1'b1;
            end else begin
                if (bus.per_data_write_n != 2'b11 || bus.per_data_read_n != 2'b11) begin
                    chk("strobe_exclusive",
                        32'(bus.per_data_write_n != 2'b11 && bus.per_data_read_n != 2'b11), 32'd0);
                    if (ns == 0) begin
                        a0 = bus.per_address; d0 = bus.per_data_in;
                    end else if (bus.per_address != a0 || bus.per_data_in != d0) begin
                        stab = 1'b0;
                    end
                    ns++;
                    sv = (bus.per_data_write_n != 2'b11) ? bus.per_data_write_n : bus.per_data_read_n;
                end
                if (bus.req_err) chk("err_qualified", 32'(bus.req_done != 2'b00), 32'd1);
                if (bus.req_ack != 2'b00) begin
                    arec.who = int'(bus.req_ack[1]);
                    arec.cyc = cyc;
                    aq.push_back(arec);
                end
                if (bus.req_done != 2'b00) begin
                    chk("done_onehot", 32'(bus.req_done == 2'b01 || bus.req_done == 2'b10), 32'd1);
                    if (ns > 0 && (bus.per_address != a0 || bus.per_data_in != d0)) stab = 1'b0;
                    drec.who    = int'(bus.req_done[1]);
                    drec.rdata  = bus.req_rdata;
                    drec.err    = bus.req_err;
                    drec.cyc    = cyc;
                    drec.ns     = ns;
                    drec.sv     = sv;
                    drec.addr   = bus.per_address;
                    drec.wd     = bus.per_data_in;
                    drec.stable = stab;
                    dq.push_back(drec);
                    ns = 0; sv = 2'b11; stab = 1'b1;
                end
            end
        end
    end

    task automatic push_item(input int r, input item_t it);
        if (r == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_last = 1;
        rd_delay = 0;
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int t;
        t = 0;
        while (dq.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (dq.size() < n) chk({nm, "/done_count"}, 32'(dq.size()), 32'(n));
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c0;
        item_t it;
        done_t d;
        per_word = v.pdata;
        rd_delay = v.dly;
        @(posedge clk); #1;
        aq.delete();
        dq.delete();
        c0 = cyc;
        it.wr = v.wr; it.txn = v.txn; it.addr = v.addr; it.wd = v.wd;
        push_item(v.r, it);
        wait_done(1, 2000, nm);
        if (dq.size() == 0) return;
        d = dq.pop_front();
        chk({nm, "/who"},     32'(d.who), 32'(v.r));
        chk({nm, "/rdata"},   d.rdata, v.xrd);
        chk({nm, "/err"},     32'(d.err), 32'(v.xerr));
        chk({nm, "/latency"}, 32'(d.cyc - c0 + 1), 32'(v.xlat));
        chk({nm, "/strobes"}, 32'(d.ns), 32'(v.xns));
        chk({nm, "/strobe"},  32'(d.sv), v.xerr ? 32'd3 : 32'(v.txn));
        chk({nm, "/addr"},    32'(d.addr), 32'(v.addr));
        chk({nm, "/stable"},  32'(d.stable), 32'd1);
        if (v.wr) chk({nm, "/wdata"}, d.wd, v.wd);
        chk({nm, "/acks"}, 32'(aq.size()), 32'd1);
        if (aq.size() == 1) begin
            chk({nm, "/ack_who"}, 32'(aq[0].who), 32'(v.r));
            chk({nm, "/ack_cyc"}, 32'(aq[0].cyc - c0), 32'd1);
        end
        @(negedge clk);
        chk({nm, "/rdata_hold"}, bus.req_rdata, v.xrd);
    endtask

    vec_t  vecs[8];
    item_t m0[$];
    item_t m1[$];
    item_t it;
    done_t d;
    int    ew;
    item_t ei;
    int    i0, i1, n0, n1, nd, t;

    initial begin
        vecs[0] = '{0, 1'b1, 2'b10, 6'h04, 32'h1234_5678, 32'h0,         0, 32'h0,         1'b0, 3, 1};
        vecs[1] = '{1, 1'b0, 2'b00, 6'h08, 32'h0,         32'hAABB_CCDD, 4, 32'h0000_00DD, 1'b0, 7, 5};
        vecs[2] = '{0, 1'b0, 2'b01, 6'h3F, 32'h0,         32'hCAFE_F00D, 0, 32'h0000_F00D, 1'b0, 3, 1};
        vecs[3] = '{1, 1'b0, 2'b10, 6'h10, 32'h0,         32'h89AB_CDEF, 2, 32'h89AB_CDEF, 1'b0, 5, 3};
        vecs[4] = '{1, 1'b0, 2'b11, 6'h12, 32'h0,         32'h1111_2222, 0, 32'h0,         1'b1, 2, 0};
        vecs[5] = '{0, 1'b1, 2'b11, 6'h05, 32'hFFFF_FFFF, 32'h0,         0, 32'h0,         1'b1, 2, 0};
        vecs[6] = '{1, 1'b1, 2'b00, 6'h21, 32'h0000_00A5, 32'h0,         0, 32'h0,         1'b0, 3, 1};
        vecs[7] = '{0, 1'b0, 2'b00, 6'h00, 32'h0,         32'hFFFF_FFFF, 1, 32'h0000_00FF, 1'b0, 4, 2};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset/write_n", 32'(bus.per_data_write_n), 32'd3);
        chk("reset/read_n",  32'(bus.per_data_read_n), 32'd3);
        chk("reset/address", 32'(bus.per_address), 32'd0);
        chk("reset/data_in", bus.per_data_in, 32'd0);
        chk("reset/rdata",   bus.req_rdata, 32'd0);
        chk("reset/ack_done_err", {27'd0, bus.req_ack, bus.req_done, bus.req_err}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef ARB_TIMEOUT_EN
        run_vec('{1, 1'b0, 2'b10, 6'h11, 32'h0, 32'h0, 1000000, 32'hDEAD_BEEF, 1'b1, 257, 255}, "timeout");
`else
        @(posedge clk); #1;
        dq.delete();
        rd_delay = 1000000;
        it.wr = 1'b0; it.txn = 2'b01; it.addr = 6'h13; it.wd = '0;
        push_item(1, it);
        repeat (1000) @(posedge clk);
        #1;
        chk("no_timeout/read_n", 32'(bus.per_data_read_n), 32'd1);
        chk("no_timeout/done",   32'(dq.size()), 32'd0);
`endif

        // Continuous contention: strict alternation, one IDLE cycle between grants.
        do_reset();
        @(posedge clk); #1;
        aq.delete();
        dq.delete();
        for (int k = 0; k < 3; k++) begin
            it.wr = 1'b1; it.txn = 2'b10; it.addr = 6'(k * 2);     it.wd = 32'(k);       push_item(0, it);
            it.wr = 1'b1; it.txn = 2'b10; it.addr = 6'(k * 2 + 1); it.wd = 32'(k + 100); push_item(1, it);
        end
        wait_done(6, 200, "alternate");
        chk("alternate/acks", 32'(aq.size()), 32'd6);
        for (int k = 0; k < 6 && k < aq.size(); k++) begin
            chk($sformatf("alternate/grant%0d", k), 32'(aq[k].who), 32'(k % 2));
            if (k > 0) chk($sformatf("alternate/gap%0d", k), 32'(aq[k].cyc - aq[k-1].cyc), 32'd3);
        end

        // Reset during a read wait.
        use_hash = 1'b0; rand_rdy = 1'b0; spur = 1'b0;
        rd_delay = 1000000;
        @(posedge clk); #1;
        aq.delete();
        dq.delete();
        it.wr = 1'b0; it.txn = 2'b10; it.addr = 6'h2A; it.wd = '0;
        push_item(0, it);
        t = 0;
        while (bus.per_data_read_n == 2'b11 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_mid/read_started", 32'(bus.per_data_read_n), 32'd2);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid/read_n",  32'(bus.per_data_read_n), 32'd3);
        chk("rst_mid/write_n", 32'(bus.per_data_write_n), 32'd3);
        chk("rst_mid/address", 32'(bus.per_address), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_last = 1;
        rd_delay = 0;
        @(posedge clk); #1;
        it.wr = 1'b1; it.txn = 2'b10; it.addr = 6'h01; it.wd = 32'h0A; push_item(0, it);
        it.wr = 1'b1; it.txn = 2'b10; it.addr = 6'h02; it.wd = 32'h0B; push_item(1, it);
        wait_done(2, 100, "rst_mid");
        chk("rst_mid/no_stale_done", 32'(dq.size()), 32'd2);
        if (aq.size() > 1) chk("rst_mid/first_grant", 32'(aq[1].who), 32'd0);
        else chk("rst_mid/ack_count", 32'(aq.size()), 32'd2);

        // Randomized traffic against a transaction-level round-robin model.
        do_reset();
        use_hash = 1'b1; rand_rdy = 1'b1; spur = 1'b1;
        for (int round = 0; round < 4; round++) begin
            @(posedge clk); #1;
            dq.delete();
            m0.delete();
            m1.delete();
            n0 = $urandom_range(3, 10);
            n1 = $urandom_range(3, 10);
            for (int k = 0; k < n0 + n1; k++) begin
                it.wr = 1'($urandom_range(0, 1));
                it.txn = 2'($urandom_range(0, 3));
                it.addr = 6'($urandom_range(0, 63));
                it.wd = $urandom;
                if (k < n0) begin m0.push_back(it); push_item(0, it); end
                else        begin m1.push_back(it); push_item(1, it); end
            end
            wait_done(n0 + n1, 3000, $sformatf("rand%0d", round));
            nd = dq.size();
            i0 = 0; i1 = 0;
            for (int k = 0; k < n0 + n1; k++) begin
                if (i0 < n0 && i1 < n1) ew = 1 - model_last;
                else                    ew = (i0 < n0) ? 0 : 1;
                model_last = ew;
                if (ew == 0) begin ei = m0[i0]; i0++; end
                else         begin ei = m1[i1]; i1++; end
                if (k < nd) begin
                    d = dq[k];
                    chk($sformatf("rand%0d.%0d/who", round, k), 32'(d.who), 32'(ew));
                    chk($sformatf("rand%0d.%0d/err", round, k), 32'(d.err), 32'(ei.txn == 2'b11));
                    chk($sformatf("rand%0d.%0d/rdata", round, k), d.rdata,
                        (ei.txn == 2'b11 || ei.wr) ? 32'd0 : width_mask(ei.txn, pdata_of(ei.addr)));
                    chk($sformatf("rand%0d.%0d/strobe", round, k), 32'(d.sv), 32'(ei.txn));
                    chk($sformatf("rand%0d.%0d/addr", round, k), 32'(d.addr), 32'(ei.addr));
                    chk($sformatf("rand%0d.%0d/stable", round, k), 32'(d.stable), 32'd1);
                    if (ei.txn != 2'b11 && ei.wr) begin
                        chk($sformatf("rand%0d.%0d/wdata", round, k), d.wd, ei.wd);
                        chk($sformatf("rand%0d.%0d/wcycles", round, k), 32'(d.ns), 32'd1);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/tqvp_bus_arbiter.md
Name: tqvp_bus_arbiter

Overview:
Two-requester arbiter that shares one TinyQV peripheral register port (e.g. tqvp_CORDIC) between the SPI register bridge (requester 0) and a local command sequencer (requester 1).
- Round-robin grant; one transaction in flight at a time.
- Drives the peripheral's address, data_in and data_write_n/data_read_n strobes, waits for data_ready on reads, and returns width-masked read data to the winner.

Parameters:
ADDR_W, 6, peripheral register address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles a read waits for per_data_ready (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  2  per-requester request; held until ack
req_write  in  2  per-requester 1=write, 0=read
req_txn  in  2x2  per-requester width: 00 byte, 01 half, 10 word, 11 illegal
req_addr  in  2xADDR_W  per-requester register address
req_wdata  in  2xDATA_W  per-requester write data
req_ack  out  2  one-cycle pulse: request accepted, fields latched
req_done  out  2  one-cycle pulse: transaction complete, rdata valid
req_rdata  out  DATA_W  read data for the completing requester
req_err  out  1  qualifies req_done: illegal txn or timeout
per_address  out  ADDR_W  to peripheral address
per_data_in  out  DATA_W  to peripheral data_in
per_data_write_n  out  2  to peripheral; 11 = idle
per_data_read_n  out  2  to peripheral; 11 = idle
per_data_out  in  DATA_W  from peripheral
per_data_ready  in  1  from peripheral; read data valid

Behaviour:
Clock and reset: one clock, clk; reset rst is asynchronous and active-high.

Reset values:
- per_data_write_n = per_data_read_n = 11.
- per_address, per_data_in, req_rdata = 0.
- req_ack, req_done, req_err = 0.
- Round-robin pointer last = 1, so requester 0 wins the first contention.

FSM states: IDLE, WRITE, READ, DONE.

IDLE:
- If any req_valid, grant: requester != last wins when both are valid; otherwise the only valid requester wins. Set last = winner.
- Latch addr, wdata, txn and write of the winner. Pulse req_ack[winner] on the next cycle.
- Go to DONE (with req_err) if txn = 11; else WRITE if write; else READ.
- Arbitration uses only registered state, so nothing is combinational from req_valid to req_ack.

WRITE:
- per_data_write_n = latched txn for exactly 1 cycle, then DONE.
- data_ready is ignored for writes.

READ:
- per_data_read_n = latched txn, held each cycle until per_data_ready = 1.
- In the ready cycle, capture per_data_out with masking: txn 00 zeroes [31:8]; txn 01 zeroes [31:16].
- Then DONE.
- per_data_ready seen outside READ is ignored.

DONE:
- req_done[winner] pulses for 1 cycle with req_rdata (0 for writes and errors) and req_err.
- Strobes return to 11. Next state IDLE.
- req_rdata holds its value until the next DONE.

Timing and ordering:
- Write latency: valid to done = 3 cycles (IDLE, WRITE, DONE).
- Read latency: 3 + the number of cycles spent waiting for ready.
- Back-to-back transactions have at least 1 IDLE cycle between them.
- per_address and per_data_in stay stable from WRITE/READ entry through DONE.
- The strobes are never both non-11 in the same cycle.

Requester rules:
- A requester deasserting valid before ack is a protocol violation; the arbiter samples valid only in IDLE.
- A requester that drops valid after ack does not abort its transaction.
- Simultaneous valid on both requesters: strict alternation across consecutive grants.

Reset mid-operation: asynchronous return to IDLE with reset values; the in-flight transaction is lost and no done pulse is generated.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an 8-bit counter (sized to TIMEOUT) increments in READ. On reaching TIMEOUT without per_data_ready, go to DONE with req_err = 1 and req_rdata = 32'hDEAD_BEEF; the read strobe drops to 11.
- Undefined: READ waits indefinitely, the counter is not synthesised, and req_err asserts only for txn = 11.

Decomposition:
Shared package tqvp_bus_pkg holds:
- state enum (IDLE, WRITE, READ, DONE);
- txn width localparams TXN_BYTE = 2'b00, TXN_HALF = 2'b01, TXN_WORD = 2'b10, TXN_NONE = 2'b11;
- TIMEOUT_DATA = 32'hDEAD_BEEF.

One sub-module is natural: tqvp_rdata_mask, a combinational txn-width read-data masker reused by the SPI harness.

Test Plan:
- Req0 write, addr 0x04, data 0x12345678, txn 10 -> per_data_write_n = 10 for exactly 1 cycle with per_address = 0x04 and per_data_in = 0x12345678; req_ack[0], then req_done[0], err = 0.
- Req1 read, addr 0x08, txn 00; peripheral returns 0xAABBCCDD with ready after 4 cycles -> read_n held at 00 for 5 cycles; req_rdata = 0x000000DD, done[1].
- Both requesters valid continuously, 6 word writes -> grant order 0,1,0,1,0,1, with 1 IDLE cycle between each transaction.
- req_txn = 11 on req0 -> no strobe ever leaves 11; done[0] with err = 1 and rdata = 0.
- With ARB_TIMEOUT_EN, a read with per_data_ready never asserted -> done after 255 READ cycles with err = 1 and rdata = 0xDEADBEEF; without the macro, still in READ at cycle 1000.
- rst asserted during the READ wait -> strobes are 11 immediately (asynchronously), no done pulse, next grant goes to requester 0.
